// File: rtl/riscv_alu.sv
// Registered 32-bit RISC-V integer ALU: one-cycle latency result, zero flag and valid strobe.
// Reset is synchronous active-low and takes priority over any operation at the same edge.
module riscv_alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [3:0]  ALUctl,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] ALUout,
  output logic        zero,
  output logic        valid_out
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;
  localparam logic [3:0] OP_NOR  = 4'b1100;

  logic [31:0] result;
  logic [4:0]  shamt;

  assign shamt = B[4:0];

  // Unused encodings deliberately yield zero so the branch logic sees zero=1.
  always_comb begin
    result = 32'd0;
    case (ALUctl)
      OP_AND:  result = A & B;
      OP_OR:   result = A | B;
      OP_ADD:  result = A + B;
      OP_XOR:  result = A ^ B;
      OP_SLL:  result = A << shamt;
      OP_SRL:  result = A >> shamt;
      OP_SUB:  result = A - B;
      OP_SLT:  result = ($signed(A) < $signed(B)) ? 32'd1 : 32'd0;
      OP_SLTU: result = (A < B) ? 32'd1 : 32'd0;
      OP_SRA:  result = $unsigned($signed(A) >>> shamt);
      OP_NOR:  result = ~(A | B);
      default: result = 32'd0;
    endcase
  end

  // zero is loaded from the same next-state value as ALUout so the two never disagree.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ALUout    <= 32'd0;
      zero      <= 1'b1;
      valid_out <= 1'b0;
    end else begin
      valid_out <= valid_in;
      if (valid_in) begin
        ALUout <= result;
        zero   <= (result == 32'd0);
      end
    end
  end

endmodule

// File: tb/tb_riscv_alu.sv
// Self-checking bench for riscv_alu: directed vectors with literal expectations plus
// randomized traffic checked every cycle against an arithmetic reference model.
module tb_riscv_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic [3:0]  ALUctl;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] ALUout;
  logic        zero;
  logic        valid_out;

  int checks = 0;
  int errors = 0;

  logic [31:0] mOut;
  logic        mZero;
  logic        mValid;

  riscv_alu dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .ALUctl    (ALUctl),
    .A         (A),
    .B         (B),
    .ALUout    (ALUout),
    .zero      (zero),
    .valid_out (valid_out)
  );

  always #5 clk = ~clk;

  // Reference arithmetic built from integer division/multiplication and biased compares.
  function automatic logic [31:0] refAlu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    longint unsigned wa;
    longint unsigned wb;
    longint unsigned pw;
    longint unsigned r;
    wa = {32'd0, a};
    wb = {32'd0, b};
    pw = 64'd1 << (b % 32);
    case (c)
      4'd0:  r = wa & wb;
      4'd1:  r = wa | wb;
      4'd2:  r = (wa + wb) % 64'h1_0000_0000;
      4'd3:  r = wa ^ wb;
      4'd4:  r = (wa * pw) % 64'h1_0000_0000;
      4'd5:  r = wa / pw;
      4'd6:  r = (wa + 64'h1_0000_0000 - wb) % 64'h1_0000_0000;
      4'd7:  r = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 64'd1 : 64'd0;
      4'd8:  r = (wa < wb) ? 64'd1 : 64'd0;
      4'd9:  r = a[31] ? ({32'd0, ~a} / pw) ^ 64'h0000_0000_FFFF_FFFF : wa / pw;
      4'd12: r = (wa | wb) ^ 64'h0000_0000_FFFF_FFFF;
      default: r = 64'd0;
    endcase
    return r[31:0];
  endfunction

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic vld, input logic [3:0] c,
                               input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    rst_n    = rst;
    valid_in = vld;
    ALUctl   = c;
    A        = a;
    B        = b;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] expOut,
                             input logic expZero, input logic expValid);
    @(posedge clk);
    #2;
    compare({name, ".out"}, ALUout, expOut);
    compare({name, ".zero"}, {31'd0, zero}, {31'd0, expZero});
    compare({name, ".valid"}, {31'd0, valid_out}, {31'd0, expValid});
  endtask

  // Per-cycle model update from the inputs seen at the edge, then compare just after it.
  always @(posedge clk) begin
    if (!rst_n) begin
      mOut   = 32'd0;
      mValid = 1'b0;
    end else begin
      mValid = valid_in;
      if (valid_in) mOut = refAlu(ALUctl, A, B);
    end
    mZero = (mOut == 32'd0);
    #1;
    compare("model.out", ALUout, mOut);
    compare("model.zero", {31'd0, zero}, {31'd0, mZero});
    compare("model.valid", {31'd0, valid_out}, {31'd0, mValid});
  end

  initial begin
    logic [31:0] specials [8];
    logic [31:0] ra;
    logic [31:0] rb;
    specials = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF,
                 32'h1F, 32'h20, 32'h21};

    rst_n = 1'b0; valid_in = 1'b1; ALUctl = 4'd2; A = 32'd9; B = 32'd1;
    checkOutput("reset1", 32'd0, 1'b1, 1'b0);
    checkOutput("reset2", 32'd0, 1'b1, 1'b0);

    applyStimulus(1, 1, 4'b0000, 32'h0000_000F, 32'h0000_000A); checkOutput("and",   32'h0000_000A, 0, 1);
    applyStimulus(1, 1, 4'b0001, 32'h0000_0000, 32'h0000_000A); checkOutput("or",    32'h0000_000A, 0, 1);
    applyStimulus(1, 1, 4'b1100, 32'h0000_0000, 32'h0000_000A); checkOutput("nor",   32'hFFFF_FFF5, 0, 1);
    applyStimulus(1, 1, 4'b0011, 32'h0000_000A, 32'h0000_000A); checkOutput("xor",   32'h0,         1, 1);
    applyStimulus(1, 1, 4'b0010, 32'd9,         32'd1);         checkOutput("add",   32'd10,        0, 1);
    applyStimulus(1, 1, 4'b0110, 32'd8,         32'd2);         checkOutput("sub",   32'd6,         0, 1);
    applyStimulus(1, 1, 4'b0110, 32'd5,         32'd5);         checkOutput("subz",  32'd0,         1, 1);
    applyStimulus(1, 1, 4'b0010, 32'hFFFF_FFFF, 32'd1);         checkOutput("addw",  32'd0,         1, 1);
    applyStimulus(1, 1, 4'b0010, 32'h7FFF_FFFF, 32'd1);         checkOutput("addo",  32'h8000_0000, 0, 1);
    applyStimulus(1, 1, 4'b0111, 32'd8,         32'd9);         checkOutput("slt1",  32'd1,         0, 1);
    applyStimulus(1, 1, 4'b0111, 32'h0000_000A, 32'd9);         checkOutput("slt0",  32'd0,         1, 1);
    applyStimulus(1, 1, 4'b0111, 32'hFFFF_FFFF, 32'd1);         checkOutput("sltn",  32'd1,         0, 1);
    applyStimulus(1, 1, 4'b1000, 32'hFFFF_FFFF, 32'd1);         checkOutput("sltu",  32'd0,         1, 1);
    applyStimulus(1, 1, 4'b0100, 32'd1,         32'd31);        checkOutput("sll",   32'h8000_0000, 0, 1);
    applyStimulus(1, 1, 4'b0101, 32'h8000_0000, 32'd4);         checkOutput("srl",   32'h0800_0000, 0, 1);
    applyStimulus(1, 1, 4'b1001, 32'h8000_0000, 32'd4);         checkOutput("sra",   32'hF800_0000, 0, 1);
    applyStimulus(1, 1, 4'b0100, 32'd1,         32'h21);        checkOutput("sllm",  32'd2,         0, 1);
    applyStimulus(1, 0, 4'b0010, 32'd100,       32'd200);       checkOutput("hold",  32'd2,         0, 0);
    applyStimulus(1, 1, 4'b0010, 32'd3,         32'd4);         checkOutput("resume",32'd7,         0, 1);
    applyStimulus(1, 1, 4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF); checkOutput("unused",32'd0,         1, 1);
    applyStimulus(1, 1, 4'b0001, 32'h1234_5678, 32'd0);         checkOutput("pre",   32'h1234_5678, 0, 1);
    applyStimulus(0, 1, 4'b0001, 32'hDEAD_BEEF, 32'd0);         checkOutput("midrst",32'd0,         1, 0);
    applyStimulus(1, 1, 4'b0011, 32'hF0F0_F0F0, 32'h0F0F_0F0F); checkOutput("after", 32'hFFFF_FFFF, 0, 1);

    for (int i = 0; i < 3000; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 7)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 7)] : $urandom;
      applyStimulus(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) != 0),
                    4'($urandom_range(0, 15)), ra, rb);
    end
    @(negedge clk);
    valid_in = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
